// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: instruction width, the bubble instruction
// and the fetch-stage state encoding.
package rv_pipe_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, redirect mux and a
// req/ready handshake to instruction memory; emits NOP bubbles when idle.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            NextPCSrc_in,
  input  logic [rv_pipe_pkg::INSTR_W-1:0] branch_target_in,
  input  logic                            hazard_detection,
  output logic                            imem_req,
  output logic [rv_pipe_pkg::INSTR_W-1:0] imem_addr,
  input  logic                            imem_ready,
  input  logic [rv_pipe_pkg::INSTR_W-1:0] imem_rdata,
  output logic [rv_pipe_pkg::INSTR_W-1:0] instruction_out,
  output logic [rv_pipe_pkg::INSTR_W-1:0] pc_out,
  output logic [rv_pipe_pkg::INSTR_W-1:0] sum_out,
  output logic                            fetch_valid
);

  import rv_pipe_pkg::*;

  fetch_state_e       r_state;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_holdInstr;
  logic [INSTR_W-1:0] r_dropAddr;

  fetch_state_e       w_nextState;
  logic [INSTR_W-1:0] w_nextPc;
  logic [INSTR_W-1:0] w_nextHoldInstr;
  logic [INSTR_W-1:0] w_nextDropAddr;
  logic [INSTR_W-1:0] w_pcPlus4;
  logic [INSTR_W-1:0] w_target;
  logic               w_readyEff;

  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_target  = branch_target_in & 32'hFFFF_FFFC;
  assign pc_out    = r_pc;
  assign sum_out   = w_pcPlus4;

  // A ready pulse only counts while we are actually requesting.
  assign w_readyEff = imem_ready & imem_req;

  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = r_pc;
    fetch_valid     = 1'b0;
    instruction_out = NOP_INSTR;
    if (!rst) begin
      unique case (r_state)
        FETCH: begin
          imem_req  = 1'b1;
          imem_addr = r_pc;
          if (imem_ready) begin
            fetch_valid     = 1'b1;
            instruction_out = imem_rdata;
          end
        end
        HOLD: begin
          fetch_valid     = 1'b1;
          instruction_out = r_holdInstr;
        end
        DROP: begin
          imem_req  = 1'b1;
          imem_addr = r_dropAddr;
        end
        default: ;
      endcase
    end
  end

  // Priority: redirect, drop completion, stall capture, advance, hold.
  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextHoldInstr = r_holdInstr;
    w_nextDropAddr  = r_dropAddr;
    if (NextPCSrc_in) begin
      w_nextPc = w_target;
      if (r_state == FETCH && !w_readyEff) begin
        w_nextDropAddr = r_pc;
        w_nextState    = DROP;
      end else if (r_state == DROP && !w_readyEff) begin
        w_nextState = DROP;
      end else begin
        w_nextState = FETCH;
      end
    end else if (r_state == DROP && w_readyEff) begin
      w_nextState = FETCH;
    end else if (fetch_valid && hazard_detection) begin
      w_nextHoldInstr = instruction_out;
      w_nextState     = HOLD;
    end else if (fetch_valid) begin
      w_nextPc    = w_pcPlus4;
      w_nextState = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_holdInstr <= NOP_INSTR;
      r_dropAddr  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_holdInstr <= w_nextHoldInstr;
      r_dropAddr  <= w_nextDropAddr;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage: reset, streaming, wait states,
// stall/hold, redirect during wait and during drop, and PC wrap.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        nextPcSrc;
  logic [31:0] branchTarget;
  logic        hazard;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic [31:0] sumOut;
  logic        fetchValid;

  logic        wrapReq;
  logic [31:0] wrapAddr;
  logic [31:0] wrapInstr;
  logic [31:0] wrapPc;
  logic [31:0] wrapSum;
  logic        wrapValid;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .NextPCSrc_in(nextPcSrc), .branch_target_in(branchTarget),
    .hazard_detection(hazard), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ready(imemReady), .imem_rdata(imemRdata), .instruction_out(instrOut),
    .pc_out(pcOut), .sum_out(sumOut), .fetch_valid(fetchValid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst), .NextPCSrc_in(1'b0), .branch_target_in(32'h0),
    .hazard_detection(1'b0), .imem_req(wrapReq), .imem_addr(wrapAddr),
    .imem_ready(1'b1), .imem_rdata(32'h0), .instruction_out(wrapInstr),
    .pc_out(wrapPc), .sum_out(wrapSum), .fetch_valid(wrapValid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checking.
  task automatic applyStimulus(input logic r, input logic ns, input logic [31:0] tgt,
                               input logic hz, input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    rst = r; nextPcSrc = ns; branchTarget = tgt; hazard = hz;
    imemReady = rdy; imemRdata = rd;
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    checkOutput({tag, ".req"},   {31'b0, imemReq},    {31'b0, req});
    if (req) checkOutput({tag, ".addr"}, imemAddr, addr);
    checkOutput({tag, ".valid"}, {31'b0, fetchValid}, {31'b0, valid});
    checkOutput({tag, ".instr"}, instrOut, instr);
    checkOutput({tag, ".pc"},    pcOut, pc);
    checkOutput({tag, ".sum"},   sumOut, pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; nextPcSrc = 1'b0; branchTarget = '0; hazard = 1'b0;
    imemReady = 1'b0; imemRdata = '0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
      checkFetch("reset", 0, 0, 0, NOP, 32'h0);
      checkOutput("wrapResetPc",  wrapPc,  32'hFFFF_FFFC);
      checkOutput("wrapResetSum", wrapSum, 32'h0000_0000);
      checkOutput("wrapResetReq", {31'b0, wrapReq}, 32'h0);
    end

    // Zero-wait streaming from address 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, (i * 4) ^ KEY);
      checkFetch($sformatf("stream%0d", i), 1, i * 4, 1, (i * 4) ^ KEY, i * 4);
      if (i == 0) checkOutput("wrapFirstAddr", wrapAddr, 32'hFFFF_FFFC);
      if (i == 1) checkOutput("wrapSecondAddr", wrapAddr, 32'h0000_0000);
    end

    // Three wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'hBAD0_0000);
      checkFetch($sformatf("wait%0d", i), 1, 32'h10, 0, NOP, 32'h10);
    end
    applyStimulus(0, 0, 0, 0, 1, 32'h1111_1111);
    checkFetch("waitDone", 1, 32'h10, 1, 32'h1111_1111, 32'h10);

    // Stream 0x14..0x1C, then stall on 0x20
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'h14 + i * 4);
      checkFetch($sformatf("preStall%0d", i), 1, 32'h14 + i * 4, 1, 32'h14 + i * 4, 32'h14 + i * 4);
    end
    applyStimulus(0, 0, 0, 1, 1, 32'h00A0_0093);
    checkFetch("stallCapture", 1, 32'h20, 1, 32'h00A0_0093, 32'h20);
    applyStimulus(0, 0, 0, 1, 0, 32'hBAD0_0001);
    checkFetch("stallHold", 0, 0, 1, 32'h00A0_0093, 32'h20);
    applyStimulus(0, 0, 0, 0, 0, 32'hBAD0_0002);
    checkFetch("stallRelease", 0, 0, 1, 32'h00A0_0093, 32'h20);

    // Resume at 0x24 and stream up to 0x2C
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'h24 + i * 4);
      checkFetch($sformatf("resume%0d", i), 1, 32'h24 + i * 4, 1, 32'h24 + i * 4, 32'h24 + i * 4);
    end

    // Redirect while the request at 0x30 is pending
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkFetch("pend30", 1, 32'h30, 0, NOP, 32'h30);
    applyStimulus(0, 1, 32'h103, 0, 0, 0);
    checkFetch("redirPend", 1, 32'h30, 0, NOP, 32'h30);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkFetch("drop0", 1, 32'h30, 0, NOP, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkFetch("dropDone", 1, 32'h30, 0, NOP, 32'h100);

    // Fetch at 0x100 with a same-cycle redirect to 0x40
    applyStimulus(0, 1, 32'h40, 0, 1, 32'h0000_0100);
    checkFetch("fetch100", 1, 32'h100, 1, 32'h0000_0100, 32'h100);
    applyStimulus(0, 0, 0, 1, 1, 32'h1234_5678);
    checkFetch("fetch40", 1, 32'h40, 1, 32'h1234_5678, 32'h40);

    // Redirect and stall together while holding at 0x40
    applyStimulus(0, 1, 32'h200, 1, 0, 0);
    checkFetch("holdRedir", 0, 0, 1, 32'h1234_5678, 32'h40);

    // Redirect again during a drop: newest target wins, drop address held
    applyStimulus(0, 1, 32'h300, 0, 0, 0);
    checkFetch("fetch200", 1, 32'h200, 0, NOP, 32'h200);
    applyStimulus(0, 1, 32'h406, 0, 0, 0);
    checkFetch("dropRedir", 1, 32'h200, 0, NOP, 32'h300);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkFetch("dropDone2", 1, 32'h200, 0, NOP, 32'h404);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0404);
    checkFetch("fetch404", 1, 32'h404, 1, 32'h0000_0404, 32'h404);

    // Mid-request reset returns to RESET_PC
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkFetch("midReset", 0, 0, 0, NOP, 32'h408);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkFetch("afterReset", 1, 32'h0, 0, NOP, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and drives its instruction/PC/PC+4 inputs.
- Owns the PC register, the PC+4 adder, the redirect mux and a req/ready handshake to instruction memory.
- Emits a NOP bubble whenever no fetched instruction is available, so IF/ID never captures garbage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- NextPCSrc_in  in  1  taken branch/jump from the later stage; redirect.
- branch_target_in  in  32  redirect target; bits [1:0] ignored (forced 0).
- hazard_detection  in  1  load-use stall; hold the current instruction.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  memory response; imem_rdata valid this cycle; only meaningful while imem_req=1.
- imem_rdata  in  32  fetched instruction.
- instruction_out  out  32  to IF/ID instruction_in.
- pc_out  out  32  to IF/ID pc_out_in.
- sum_out  out  32  to IF/ID sum_out_in (pc+4).
- fetch_valid  out  1  instruction_out is a real fetched instruction.

Behaviour:
- Registers: pc[31:0], state, hold_instr[31:0], drop_addr[31:0]. Outputs are combinational from these and the inputs.
- States:
  - FETCH: request pc.
  - HOLD: instruction buffered during a stall.
  - DROP: outstanding request being discarded after a redirect.
- Reset (rst=1 at edge): pc<=RESET_PC, state<=FETCH, hold_instr<=NOP_INSTR, drop_addr<=0.
- While rst=1: imem_req=0, fetch_valid=0, instruction_out=NOP_INSTR, pc_out=pc, sum_out=pc+4.
- Instruction memory shares rst, so reset mid-request abandons the request legally.
- Handshake: once imem_req=1, imem_req and imem_addr stay stable until imem_ready=1. imem_ready may arrive in the same cycle as the request (0-wait) or N cycles later.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc.
  - If imem_ready: fetch_valid=1, instruction_out=imem_rdata.
  - Otherwise: fetch_valid=0, instruction_out=NOP_INSTR.
- HOLD: imem_req=0, fetch_valid=1, instruction_out=hold_instr.
- DROP: imem_req=1, imem_addr=drop_addr, fetch_valid=0, instruction_out=NOP_INSTR. imem_rdata is discarded.
- pc_out=pc and sum_out=pc+4 (mod 2^32) in all states.
- Next-state priority, highest first:
  1. NextPCSrc_in=1: pc<={branch_target_in[31:2],2'b00}.
     - From FETCH with imem_ready=0: drop_addr<=pc, state<=DROP.
     - From DROP with imem_ready=0: stay DROP; drop_addr unchanged, pc updated to the newest target.
     - All other cases: state<=FETCH.
     - A redirect overrides a simultaneous stall.
  2. DROP and imem_ready=1: state<=FETCH, pc unchanged (already holds the target).
  3. fetch_valid=1 and hazard_detection=1: hold_instr<=instruction_out, state<=HOLD, pc unchanged.
  4. fetch_valid=1 and hazard_detection=0: pc<=pc+4, state<=FETCH.
  5. Otherwise: hold state and pc.
- Latency: 0-wait memory delivers one instruction per cycle. An instruction appears on instruction_out in the same cycle as imem_ready.
- First fetch after a redirect is requested on the cycle after NextPCSrc_in (or after DROP completes).
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no error flag.
- Stall with no valid instruction (FETCH waiting): no effect beyond holding; the request continues.

Decomposition:
- Shared rv_pipe_pkg:
  - NOP_INSTR constant.
  - Fetch-state enum (FETCH, HOLD, DROP).
  - Instruction-width constant (32).
- No sub-module; the adder and mux stay inline.

Test Plan:
- Reset: rst=1 for 2 cycles with RESET_PC=0 -> imem_req=0, instruction_out=0x00000013, pc_out=0, sum_out=4. First cycle after release: imem_req=1, imem_addr=0.
- 0-wait streaming: imem_ready=1 always, rdata=addr^0xA5A5A5A5 -> imem_addr 0,4,8,12 on consecutive cycles, fetch_valid=1 each cycle, sum_out=pc+4.
- Wait states: ready 3 cycles after req at pc=0x10 -> imem_addr stays 0x10, NOP/fetch_valid=0 for 3 cycles, then data with fetch_valid=1, next addr 0x14.
- Stall: hazard_detection=1 for 2 cycles while instruction 0x00A00093 valid at pc=0x20 -> HOLD, instruction_out stays 0x00A00093, pc_out=0x20, imem_req=0. Resumes with 0x24.
- Redirect mid-wait: req at 0x30 pending, NextPCSrc_in=1 with target 0x103 -> DROP, imem_addr held at 0x30 until ready, data discarded (fetch_valid=0). Next request at 0x100.
- Redirect+stall same cycle, and wrap: HOLD at 0x40 with NextPCSrc_in=1, hazard=1, target 0x200 -> next imem_addr=0x200. Separately, RESET_PC=0xFFFFFFFC -> sum_out=0, next fetch at 0x0.
